// File: rtl/alu_rs.sv
// Reservation station for the integer ALU: buffers dispatched micro-ops, captures
// operands from the CDB and issues the lowest-index operand-complete entry.
module alu_rs #(
    parameter int NUM_ENTRIES = 4,
    parameter int TAG_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             dispatch_valid,
    output logic             dispatch_ready,
    input  logic [2:0]       dispatch_aluop,
    input  logic [TAG_W-1:0] dispatch_rob_tag,
    input  logic             dispatch_rs1_rdy,
    input  logic [31:0]      dispatch_rs1_val,
    input  logic [TAG_W-1:0] dispatch_rs1_tag,
    input  logic             dispatch_rs2_rdy,
    input  logic [31:0]      dispatch_rs2_val,
    input  logic [TAG_W-1:0] dispatch_rs2_tag,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_data,
    output logic             issue_valid,
    input  logic             issue_ready,
    output logic [2:0]       issue_aluop,
    output logic [31:0]      issue_a,
    output logic [31:0]      issue_b,
    output logic [TAG_W-1:0] issue_rob_tag
);
    localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

    logic [NUM_ENTRIES-1:0] busy_r;
    logic [NUM_ENTRIES-1:0] rs1_rdy_r;
    logic [NUM_ENTRIES-1:0] rs2_rdy_r;
    logic [2:0]             aluop_r   [NUM_ENTRIES];
    logic [TAG_W-1:0]       rob_tag_r [NUM_ENTRIES];
    logic [31:0]            rs1_val_r [NUM_ENTRIES];
    logic [31:0]            rs2_val_r [NUM_ENTRIES];
    logic [TAG_W-1:0]       rs1_tag_r [NUM_ENTRIES];
    logic [TAG_W-1:0]       rs2_tag_r [NUM_ENTRIES];

    logic [NUM_ENTRIES-1:0] ready_vec_s;
    logic [IDX_W-1:0]       free_idx_s;
    logic [IDX_W-1:0]       issue_idx_s;
    logic                   issue_found_s;
    logic                   dispatch_fire_s;
    logic                   issue_fire_s;
    logic                   rs1_hit_s;
    logic                   rs2_hit_s;

    function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_ENTRIES-1:0] vec);
        lowest_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (vec[i]) begin
                lowest_idx = IDX_W'(i);
            end else begin
                lowest_idx = lowest_idx;
            end
        end
    endfunction

    assign ready_vec_s     = busy_r & rs1_rdy_r & rs2_rdy_r;
    assign issue_found_s   = |ready_vec_s;
    assign issue_idx_s     = lowest_idx(ready_vec_s);
    assign free_idx_s      = lowest_idx(~busy_r);
    assign dispatch_ready  = ~(&busy_r);
    assign dispatch_fire_s = dispatch_valid & dispatch_ready;
    assign issue_fire_s    = issue_found_s & issue_ready;
    // A dispatched operand whose producer broadcasts this very cycle is captured directly
    assign rs1_hit_s = cdb_valid & ~dispatch_rs1_rdy & (dispatch_rs1_tag == cdb_tag);
    assign rs2_hit_s = cdb_valid & ~dispatch_rs2_rdy & (dispatch_rs2_tag == cdb_tag);

    // Issue port: present the selected entry, drive zeros when nothing is issuable
    always_comb begin
        issue_valid   = 1'b0;
        issue_aluop   = 3'b000;
        issue_a       = 32'h0000_0000;
        issue_b       = 32'h0000_0000;
        issue_rob_tag = '0;
        if (issue_found_s) begin
            issue_valid   = 1'b1;
            issue_aluop   = aluop_r[issue_idx_s];
            issue_a       = rs1_val_r[issue_idx_s];
            issue_b       = rs2_val_r[issue_idx_s];
            issue_rob_tag = rob_tag_r[issue_idx_s];
        end else begin
            issue_valid   = 1'b0;
        end
    end

    // Entry state: reset/flush clears everything, otherwise wakeup, retire and dispatch write
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            busy_r    <= '0;
            rs1_rdy_r <= '0;
            rs2_rdy_r <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                aluop_r[i]   <= 3'b000;
                rob_tag_r[i] <= '0;
                rs1_val_r[i] <= 32'h0000_0000;
                rs2_val_r[i] <= 32'h0000_0000;
                rs1_tag_r[i] <= '0;
                rs2_tag_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (busy_r[i] && cdb_valid && !rs1_rdy_r[i] && (rs1_tag_r[i] == cdb_tag)) begin
                    rs1_rdy_r[i] <= 1'b1;
                    rs1_val_r[i] <= cdb_data;
                end
                if (busy_r[i] && cdb_valid && !rs2_rdy_r[i] && (rs2_tag_r[i] == cdb_tag)) begin
                    rs2_rdy_r[i] <= 1'b1;
                    rs2_val_r[i] <= cdb_data;
                end
                if (issue_fire_s && (issue_idx_s == IDX_W'(i))) begin
                    busy_r[i] <= 1'b0;
                end
                // Dispatch only targets a free slot, so it never races the retire above
                if (dispatch_fire_s && (free_idx_s == IDX_W'(i))) begin
                    busy_r[i]    <= 1'b1;
                    aluop_r[i]   <= dispatch_aluop;
                    rob_tag_r[i] <= dispatch_rob_tag;
                    rs1_rdy_r[i] <= dispatch_rs1_rdy | rs1_hit_s;
                    rs1_val_r[i] <= rs1_hit_s ? cdb_data : dispatch_rs1_val;
                    rs1_tag_r[i] <= dispatch_rs1_tag;
                    rs2_rdy_r[i] <= dispatch_rs2_rdy | rs2_hit_s;
                    rs2_val_r[i] <= rs2_hit_s ? cdb_data : dispatch_rs2_val;
                    rs2_tag_r[i] <= dispatch_rs2_tag;
                end
            end
        end
    end
endmodule
